// File: rtl/ecc_pkg.sv
// Shared SECDED definitions: code geometry helpers and the encoded-word
// layout agreed between the Hamming+extended-parity encoder and the checker.
package ecc_pkg;

    // Smallest P such that 2^P >= data_width + P + 1.
    function automatic int get_parity_width(input int data_width);
        int p = 1;
        while ((1 << p) < (data_width + p + 1)) begin
            p = p + 1;
        end
        return p;
    endfunction

    // Hamming code word width, excluding the overall parity bit.
    function automatic int get_cw_width(input int data_width);
        return data_width + get_parity_width(data_width);
    endfunction

    // A non-zero syndrome only names a real bit if it lies inside the code word.
    function automatic logic get_syndrome_pos_valid(input int unsigned s,
                                                    input int data_width);
        return (s <= int'(get_cw_width(data_width)));
    endfunction

    localparam int ECC_DATA_W = 64;
    localparam int ECC_P_W    = get_parity_width(ECC_DATA_W);
    localparam int ECC_CW_W   = get_cw_width(ECC_DATA_W);

    // Encoded word as stored/transmitted: overall parity on top of the code
    // word, code word position j (1-based) at bit j-1.
    typedef struct packed {
        logic                parity;
        logic [ECC_CW_W-1:0] code_word;
    } ecc_enc_word_t;

endpackage

// File: rtl/ecc_syndrome_calc.sv
// Combinational SECDED decode: syndrome, overall parity, single-error
// correction, data extraction and error classification.
module ecc_syndrome_calc
    import ecc_pkg::*;
#(
    parameter  int DataWidth = 64,
    localparam int P         = get_parity_width(DataWidth),
    localparam int CW        = get_cw_width(DataWidth)
) (
    input  logic [CW:0]          enc_i,
    output logic [P-1:0]         syndrome_o,
    output logic                 parity_o,
    output logic [DataWidth-1:0] data_o,
    output logic                 single_err_o,
    output logic                 double_err_o
);

    // Same layout as ecc_enc_word_t, sized from the DataWidth parameter.
    typedef struct packed {
        logic          parity;
        logic [CW-1:0] code_word;
    } enc_word_t;

    enc_word_t enc;
    logic      syn_nz;
    logic      pos_ok;
    logic      flip_en;

    assign enc = enc_word_t'(enc_i);

    // Syndrome bit i covers every position whose index has bit i set,
    // including the parity positions themselves.
    for (genvar i = 0; i < P; i++) begin : g_syn
        logic [CW-1:0] sel;
        for (genvar j = 1; j <= CW; j++) begin : g_sel
            if (((j >> i) & 1) != 0) begin : g_on
                assign sel[j-1] = enc.code_word[j-1];
            end else begin : g_off
                assign sel[j-1] = 1'b0;
            end
        end
        assign syndrome_o[i] = ^sel;
    end

    assign parity_o = enc.parity ^ (^enc.code_word);

    assign syn_nz  = |syndrome_o;
    assign pos_ok  = get_syndrome_pos_valid(32'(syndrome_o), DataWidth);
    assign flip_en = parity_o & syn_nz & pos_ok;

    // Parity-bit-only errors (s==0, p==1) are single errors with no data flip.
    assign single_err_o = parity_o & (~syn_nz | pos_ok);
    assign double_err_o = syn_nz & (~parity_o | ~pos_ok);

    // Data bits sit at the non-power-of-two positions; position j holds data
    // bit j - clog2(j) - 1. Correction is applied only to those positions
    // since parity positions never reach the output.
    for (genvar j = 1; j <= CW; j++) begin : g_pos
        if ((j & (j - 1)) != 0) begin : g_data
            assign data_o[j - $clog2(j) - 1] =
                enc.code_word[j-1] ^ (flip_en && (syndrome_o == P'(j)));
        end
    end

endmodule

// File: rtl/ecc_check_stage.sv
// Registered SECDED check stage with a one-deep valid/ready output register,
// saturating error counters and an optional sticky first-error log.
// Optional feature macro: ECC_CHECK_STAGE_ERR_LOG_EN (first-error log).
module ecc_check_stage
    import ecc_pkg::*;
#(
    parameter  int DataWidth = 64,
    parameter  int CntWidth  = 16,
    localparam int P         = get_parity_width(DataWidth),
    localparam int CW        = get_cw_width(DataWidth)
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    input  logic [CW:0]          in_data_i,
    output logic                 out_valid_o,
    input  logic                 out_ready_i,
    output logic [DataWidth-1:0] out_data_o,
    output logic                 out_single_err_o,
    output logic                 out_double_err_o,
    output logic [P-1:0]         out_syndrome_o,
    input  logic                 clr_cnt_i,
    output logic [CntWidth-1:0]  single_cnt_o,
    output logic [CntWidth-1:0]  double_cnt_o,
    output logic                 err_log_valid_o,
    output logic [P-1:0]         err_log_syndrome_o,
    output logic                 err_log_double_o
);

    logic [P-1:0]         calc_syndrome;
    logic                 calc_parity;
    logic [DataWidth-1:0] calc_data;
    logic                 calc_single;
    logic                 calc_double;
    logic                 accept;

    ecc_syndrome_calc #(
        .DataWidth (DataWidth)
    ) u_calc (
        .enc_i        (in_data_i),
        .syndrome_o   (calc_syndrome),
        .parity_o     (calc_parity),
        .data_o       (calc_data),
        .single_err_o (calc_single),
        .double_err_o (calc_double)
    );

    // Register frees up in the same cycle the downstream takes the held word.
    assign in_ready_o = !out_valid_o || out_ready_i;
    assign accept     = in_valid_i && in_ready_o;

    // Classification sanity: never both flags, and odd parity always means error.
    always_comb begin
        assert (!(calc_single && calc_double));
        assert (!calc_parity || calc_single || calc_double);
    end

    // Output register: load on accept, hold while stalled.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            out_valid_o      <= 1'b0;
            out_data_o       <= '0;
            out_single_err_o <= 1'b0;
            out_double_err_o <= 1'b0;
            out_syndrome_o   <= '0;
        end else if (in_ready_o) begin
            out_valid_o <= in_valid_i;
            if (in_valid_i) begin
                out_data_o       <= calc_data;
                out_single_err_o <= calc_single;
                out_double_err_o <= calc_double;
                out_syndrome_o   <= calc_syndrome;
            end
        end
    end

    // Saturating error counters; a clear in the same cycle beats an increment.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            single_cnt_o <= '0;
            double_cnt_o <= '0;
        end else if (clr_cnt_i) begin
            single_cnt_o <= '0;
            double_cnt_o <= '0;
        end else if (accept) begin
            if (calc_single && (single_cnt_o != '1)) begin
                single_cnt_o <= single_cnt_o + 1'b1;
            end
            if (calc_double && (double_cnt_o != '1)) begin
                double_cnt_o <= double_cnt_o + 1'b1;
            end
        end
    end

`ifdef ECC_CHECK_STAGE_ERR_LOG_EN
    // Sticky first-error log; cleared together with the counters.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            err_log_valid_o    <= 1'b0;
            err_log_syndrome_o <= '0;
            err_log_double_o   <= 1'b0;
        end else if (clr_cnt_i) begin
            err_log_valid_o    <= 1'b0;
            err_log_syndrome_o <= '0;
            err_log_double_o   <= 1'b0;
        end else if (accept && (calc_single || calc_double) && !err_log_valid_o) begin
            err_log_valid_o    <= 1'b1;
            err_log_syndrome_o <= calc_syndrome;
            err_log_double_o   <= calc_double;
        end
    end
`else
    assign err_log_valid_o    = 1'b0;
    assign err_log_syndrome_o = '0;
    assign err_log_double_o   = 1'b0;
`endif

endmodule

// File: tb/tb_ecc_check_stage.sv
// Directed bench for ecc_check_stage (DataWidth=64, CntWidth=2).
module tb_ecc_check_stage;

`ifdef ECC_CHECK_STAGE_ERR_LOG_EN
    localparam bit LOG_EN = 1'b1;
`else
    localparam bit LOG_EN = 1'b0;
`endif

    // Hand-encoded vectors: position j is bit j-1, bit 71 is overall parity.
    localparam logic [71:0] W_ZERO   = 72'h00_0000_0000_0000_0000;
    localparam logic [71:0] W_ONE    = 72'h80_0000_0000_0000_0007; // clean 64'h1
    localparam logic [71:0] W_FLIP3  = 72'h80_0000_0000_0000_0003; // 64'h1, pos 3 flipped
    localparam logic [71:0] W_FLIP35 = 72'h00_0000_0000_0000_0014; // zero, pos 3+5 flipped
    localparam logic [71:0] W_PAR    = 72'h80_0000_0000_0000_0000; // overall parity only
    localparam logic [71:0] W_S71    = 72'h40_0000_0000_0000_0000; // pos 71 flipped
    localparam logic [71:0] W_S72    = 72'h80_8000_0000_0000_0080; // pos 8+64 + parity

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [71:0] in_data;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] out_data;
    logic        out_single;
    logic        out_double;
    logic [6:0]  out_syn;
    logic        clr;
    logic [1:0]  single_cnt;
    logic [1:0]  double_cnt;
    logic        log_valid;
    logic [6:0]  log_syn;
    logic        log_double;

    int passed = 0;
    int total  = 0;

    ecc_check_stage #(
        .DataWidth (64),
        .CntWidth  (2)
    ) dut (
        .clk_i              (clk),
        .rst_i              (rst),
        .in_valid_i         (in_valid),
        .in_ready_o         (in_ready),
        .in_data_i          (in_data),
        .out_valid_o        (out_valid),
        .out_ready_i        (out_ready),
        .out_data_o         (out_data),
        .out_single_err_o   (out_single),
        .out_double_err_o   (out_double),
        .out_syndrome_o     (out_syn),
        .clr_cnt_i          (clr),
        .single_cnt_o       (single_cnt),
        .double_cnt_o       (double_cnt),
        .err_log_valid_o    (log_valid),
        .err_log_syndrome_o (log_syn),
        .err_log_double_o   (log_double)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Present one word for one cycle; outputs are valid on return.
    task automatic send(input logic [71:0] w);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = w;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic do_clear();
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_data = '0; out_ready = 1'b1; clr = 1'b0;
        repeat (3) @(negedge clk);
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data} !== 74'h0)
            $display("FAIL reset_out: got %h expected 0", {out_valid, out_single, out_double, out_syn, out_data});
        else passed++;
        total++;
        if ({in_ready, single_cnt, double_cnt} !== 5'b1_00_00)
            $display("FAIL reset_ready_cnt: got %b expected 10000", {in_ready, single_cnt, double_cnt});
        else passed++;
        total++;
        if ({log_valid, log_double, log_syn} !== 9'h0)
            $display("FAIL reset_log: got %h expected 0", {log_valid, log_double, log_syn});
        else passed++;
        rst = 1'b0;
    endtask

    task automatic test_clean();
        do_clear();
        send(W_ZERO);
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data, single_cnt, double_cnt} !==
            {1'b1, 1'b0, 1'b0, 7'd0, 64'h0, 2'd0, 2'd0})
            $display("FAIL clean_zero: got %h", {out_valid, out_single, out_double, out_syn, out_data, single_cnt, double_cnt});
        else passed++;
        send(W_ONE);
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data} !== {1'b1, 1'b0, 1'b0, 7'd0, 64'h1})
            $display("FAIL clean_one: got %h expected data 1 no flags", {out_valid, out_single, out_double, out_syn, out_data});
        else passed++;
    endtask

    task automatic test_single();
        do_clear();
        send(W_FLIP3);
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data, single_cnt, double_cnt} !==
            {1'b1, 1'b1, 1'b0, 7'd3, 64'h1, 2'd1, 2'd0})
            $display("FAIL single_pos3: got %h", {out_valid, out_single, out_double, out_syn, out_data, single_cnt, double_cnt});
        else passed++;
        total++;
        if ({log_valid, log_double, log_syn} !== (LOG_EN ? {1'b1, 1'b0, 7'd3} : 9'h0))
            $display("FAIL single_log: got %h", {log_valid, log_double, log_syn});
        else passed++;
    endtask

    task automatic test_parity_only();
        do_clear();
        send(W_PAR);
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data, single_cnt} !==
            {1'b1, 1'b1, 1'b0, 7'd0, 64'h0, 2'd1})
            $display("FAIL parity_only: got %h", {out_valid, out_single, out_double, out_syn, out_data, single_cnt});
        else passed++;
    endtask

    task automatic test_boundary();
        do_clear();
        send(W_S71);
        total++;
        if ({out_single, out_double, out_syn, out_data} !== {1'b1, 1'b0, 7'd71, 64'h0})
            $display("FAIL syn_eq_cw: got %h expected single syn 71 data 0", {out_single, out_double, out_syn, out_data});
        else passed++;
        send(W_S72);
        total++;
        if ({out_single, out_double, out_syn, out_data, single_cnt, double_cnt} !==
            {1'b0, 1'b1, 7'd72, 64'h0, 2'd1, 2'd1})
            $display("FAIL syn_gt_cw: got %h", {out_single, out_double, out_syn, out_data, single_cnt, double_cnt});
        else passed++;
        total++;
        if ({log_valid, log_double, log_syn} !== (LOG_EN ? {1'b1, 1'b0, 7'd71} : 9'h0))
            $display("FAIL log_sticky: got %h", {log_valid, log_double, log_syn});
        else passed++;
    endtask

    task automatic test_double();
        do_clear();
        send(W_FLIP35);
        total++;
        if ({out_single, out_double, out_syn, out_data, single_cnt, double_cnt} !==
            {1'b0, 1'b1, 7'd6, 64'h3, 2'd0, 2'd1})
            $display("FAIL double_3_5: got %h", {out_single, out_double, out_syn, out_data, single_cnt, double_cnt});
        else passed++;
        total++;
        if ({log_valid, log_double, log_syn} !== (LOG_EN ? {1'b1, 1'b1, 7'd6} : 9'h0))
            $display("FAIL double_log: got %h", {log_valid, log_double, log_syn});
        else passed++;
    endtask

    task automatic test_backpressure();
        do_clear();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W_FLIP3;
        @(negedge clk);
        in_data = W_ZERO;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if ({in_ready, out_valid, out_single, out_double, out_syn, out_data} !==
                {1'b0, 1'b1, 1'b1, 1'b0, 7'd3, 64'h1})
                $display("FAIL stall_hold: cycle %0d got %h", i, {in_ready, out_valid, out_single, out_double, out_syn, out_data});
            else passed++;
        end
        out_ready = 1'b1;
        #1;
        total++;
        if (in_ready !== 1'b1)
            $display("FAIL ready_comb: got %b expected 1", in_ready);
        else passed++;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_single, out_double, out_syn, out_data} !== {1'b1, 1'b0, 1'b0, 7'd0, 64'h0})
            $display("FAIL stall_second: got %h expected queued zero word", {out_valid, out_single, out_double, out_syn, out_data});
        else passed++;
        @(negedge clk);
        total++;
        if ({out_valid, single_cnt} !== {1'b0, 2'd1})
            $display("FAIL stall_drain: got %b expected 0_01", {out_valid, single_cnt});
        else passed++;
    endtask

    task automatic test_back_to_back();
        do_clear();
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = W_ONE;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_single, out_double, out_data} !== {1'b1, 1'b1, 1'b0, 1'b0, 64'h1})
            $display("FAIL b2b_word0: got %h", {in_ready, out_valid, out_single, out_double, out_data});
        else passed++;
        in_data = W_S71;
        @(negedge clk);
        total++;
        if ({in_ready, out_valid, out_single, out_syn} !== {1'b1, 1'b1, 1'b1, 7'd71})
            $display("FAIL b2b_word1: got %h", {in_ready, out_valid, out_single, out_syn});
        else passed++;
        in_data = W_FLIP35;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, out_double, out_syn, single_cnt, double_cnt} !== {1'b1, 1'b1, 7'd6, 2'd1, 2'd1})
            $display("FAIL b2b_word2: got %h", {out_valid, out_double, out_syn, single_cnt, double_cnt});
        else passed++;
        @(negedge clk);
        total++;
        if (out_valid !== 1'b0)
            $display("FAIL b2b_idle: got %b expected 0", out_valid);
        else passed++;
    endtask

    task automatic test_counter_sat();
        do_clear();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = W_PAR;
        end
        @(negedge clk);
        total++;
        if ({single_cnt, double_cnt, log_valid} !== {2'd3, 2'd0, LOG_EN})
            $display("FAIL cnt_saturate: got %b expected %b", {single_cnt, double_cnt, log_valid}, {2'd3, 2'd0, LOG_EN});
        else passed++;
        in_data = W_FLIP3;
        clr     = 1'b1;
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        total++;
        if ({single_cnt, log_valid, log_syn, out_single, out_syn} !== {2'd0, 1'b0, 7'd0, 1'b1, 7'd3})
            $display("FAIL clr_wins: got %h", {single_cnt, log_valid, log_syn, out_single, out_syn});
        else passed++;
    endtask

    task automatic test_reset_mid();
        do_clear();
        @(negedge clk);
        out_ready = 1'b0;
        in_valid  = 1'b1;
        in_data   = W_FLIP3;
        @(negedge clk);
        in_valid = 1'b0;
        total++;
        if ({out_valid, in_ready, single_cnt} !== {1'b1, 1'b0, 2'd1})
            $display("FAIL pre_reset_hold: got %b", {out_valid, in_ready, single_cnt});
        else passed++;
        #2 rst = 1'b1;
        #1;
        total++;
        if ({out_valid, in_ready, single_cnt, out_data} !== {1'b0, 1'b1, 2'd0, 64'h0})
            $display("FAIL async_reset: got %h", {out_valid, in_ready, single_cnt, out_data});
        else passed++;
        @(negedge clk);
        rst       = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        total++;
        if ({out_valid, in_ready} !== 2'b01)
            $display("FAIL post_reset: got %b expected 01", {out_valid, in_ready});
        else passed++;
    endtask

    initial begin
        test_reset();
        test_clean();
        test_single();
        test_parity_only();
        test_boundary();
        test_double();
        test_backpressure();
        test_back_to_back();
        test_counter_sat();
        test_reset_mid();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
